// File: rtl/hevc_interp_pkg.sv
// Shared constants, FSM state encoding and window helper for the HEVC luma
// sub-pixel interpolation path (pixel window feeder and the 8-tap FIR stages).
// No ports: package only.
package hevc_interp_pkg;

  localparam int PIX_W      = 8;
  localparam int NUM_TAPS   = 8;
  localparam int CENTER_TAP = 3;
  // Taps to the right of the centre: a window for x needs pixel x+4 first.
  localparam int LOOKAHEAD  = NUM_TAPS - CENTER_TAP - 1;
  localparam int WIN_W      = NUM_TAPS * PIX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } win_state_t;

  // Drop tap 0, move every tap one byte down, new pixel becomes tap 7.
  function automatic logic [WIN_W-1:0] shift_window(input logic [WIN_W-1:0] win,
                                                    input logic [PIX_W-1:0] pix);
    return {pix, win[WIN_W-1:PIX_W]};
  endfunction

endpackage

// File: rtl/hevc_pixel_window_if.sv
// Handshake bundle between a raster pixel source/window sink and
// hevc_pixel_window.
//   in_pixel/in_valid/in_ready          : raster pixel stream into the block
//   out_window/out_x/out_last/out_valid : 8-tap window stream out of the block
//   out_ready                           : downstream accepts the window
// master = the side feeding pixels and taking windows; slave = the block.
interface hevc_pixel_window_if #(
  parameter int ROW_WIDTH = 64,
  parameter int PIX_W     = 8
) ();

  logic [PIX_W-1:0]                             in_pixel;
  logic                                         in_valid;
  logic                                         in_ready;
  logic [hevc_interp_pkg::NUM_TAPS*PIX_W-1:0]   out_window;
  logic [$clog2(ROW_WIDTH)-1:0]                 out_x;
  logic                                         out_last;
  logic                                         out_valid;
  logic                                         out_ready;

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_window, out_x, out_last, out_valid
  );

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_window, out_x, out_last, out_valid
  );

endinterface

// File: rtl/hevc_pixel_window_shift_reg.sv
// pixel_shift_reg: 8-byte tap register feeding the window output.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset (clears to 0)
//   preload      : fill all eight bytes with pixel (first pixel of a row)
//   shift        : shift one byte toward tap 0 and load pixel into tap 7
//   pixel        : byte to preload or shift in
//   window       : flattened taps, byte k = tap k
module pixel_shift_reg
  import hevc_interp_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             preload,
  input  logic             shift,
  input  logic [PIX_W-1:0] pixel,
  output logic [WIN_W-1:0] window
);

  // Preload wins over shift; the top never asserts both in one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window <= '0;
    end else if (preload) begin
      window <= {NUM_TAPS{pixel}};
    end else if (shift) begin
      window <= shift_window(window, pixel);
    end
  end

endmodule

// File: rtl/hevc_pixel_window.sv
// hevc_pixel_window: turns a raster luma row into one 8-tap window per
// integer position x, with edge pixels replicated at both row ends.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : in_pixel/in_valid/in_ready pixel input,
//                  out_window/out_x/out_last/out_valid/out_ready window output
// Byte k of out_window holds pixel x-3+k, clamped to the row.
module hevc_pixel_window #(
  parameter int ROW_WIDTH = 64,
  parameter int PIX_W     = 8
) (
  input  logic                clock,
  input  logic                reset,
  hevc_pixel_window_if.slave  bus
);

  import hevc_interp_pkg::*;

  localparam int XW = $clog2(ROW_WIDTH);
  localparam int NW = $clog2(ROW_WIDTH + 1);

  win_state_t       state;
  logic [NW-1:0]    n;
  logic [2:0]       f;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] next_win;
  logic [PIX_W-1:0] shift_pixel;
  logic             can_load;
  logic             in_fire;
  logic             preload;
  logic             shift;
  logic             stream_load;
  logic             flush_load;

  // The output register may be overwritten when empty or being drained.
  assign can_load = !bus.out_valid || bus.out_ready;

  // PRIME never loads the output, so it accepts regardless of backpressure.
  always_comb begin
    bus.in_ready = 1'b0;
    if (!reset) begin
      case (state)
        IDLE, PRIME: bus.in_ready = 1'b1;
        STREAM:      bus.in_ready = can_load;
        default:     bus.in_ready = 1'b0;
      endcase
    end
  end

  assign in_fire     = bus.in_valid && bus.in_ready;
  assign preload     = in_fire && (state == IDLE);
  assign stream_load = in_fire && (state == STREAM);
  assign flush_load  = (state == FLUSH) && can_load;
  assign shift       = (in_fire && (state != IDLE)) || flush_load;

  // While flushing, re-shift the last pixel of the row to pad the right edge.
  assign shift_pixel = flush_load ? win[WIN_W-1 -: PIX_W] : bus.in_pixel;
  assign next_win    = shift_window(win, shift_pixel);

  pixel_shift_reg u_shift_reg (
    .clock   (clock),
    .reset   (reset),
    .preload (preload),
    .shift   (shift),
    .pixel   (shift_pixel),
    .window  (win)
  );

  // Row sequencing: n counts accepted pixels, f counts right-edge pad windows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      n     <= '0;
      f     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            n     <= NW'(1);
            state <= PRIME;
          end
        end
        PRIME: begin
          if (in_fire) begin
            n <= n + 1'b1;
            if (n == NW'(LOOKAHEAD - 1)) state <= STREAM;
          end
        end
        STREAM: begin
          if (in_fire) begin
            n <= n + 1'b1;
            if (n == NW'(ROW_WIDTH - 1)) begin
              f     <= '0;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (can_load) begin
            f <= f + 1'b1;
            if (f == 3'(LOOKAHEAD - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage captures the post-shift window so x lags the newest pixel
  // by LOOKAHEAD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_window <= '0;
      bus.out_x      <= '0;
      bus.out_last   <= 1'b0;
      bus.out_valid  <= 1'b0;
    end else if (stream_load) begin
      bus.out_window <= next_win;
      bus.out_x      <= XW'(n - NW'(LOOKAHEAD));
      bus.out_last   <= 1'b0;
      bus.out_valid  <= 1'b1;
    end else if (flush_load) begin
      bus.out_window <= next_win;
      bus.out_x      <= XW'(ROW_WIDTH - LOOKAHEAD) + XW'(f);
      bus.out_last   <= (f == 3'(LOOKAHEAD - 1));
      bus.out_valid  <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hevc_pixel_window.sv
// Directed bench for hevc_pixel_window: an 8-pixel-row instance for the
// row, throughput, backpressure, flush-stall and reset cases, and a
// 16-pixel-row instance for the constant image.
module tb_hevc_pixel_window;

  typedef struct {
    logic [63:0] window;
    int          x;
    logic        last;
    int          cyc;
    int          rlow;
  } win_rec_t;

  logic clock = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rlow8  = 0;
  int stall8 = 0;

  win_rec_t q8[$];
  win_rec_t q16[$];

  logic [7:0] refRow [0:15];
  int         refW;

  always #5 clock = ~clock;

  hevc_pixel_window_if #(.ROW_WIDTH(8),  .PIX_W(8)) bus8 ();
  hevc_pixel_window_if #(.ROW_WIDTH(16), .PIX_W(8)) bus16 ();

  hevc_pixel_window #(.ROW_WIDTH(8), .PIX_W(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8.slave)
  );

  hevc_pixel_window #(.ROW_WIDTH(16), .PIX_W(8)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (bus16.slave)
  );

  function automatic win_rec_t makeRec(input logic [63:0] w, input int x,
                                       input logic l, input int c, input int r);
    win_rec_t rec;
    rec.window = w;
    rec.x      = x;
    rec.last   = l;
    rec.cyc    = c;
    rec.rlow   = r;
    return rec;
  endfunction

  // Records every accepted window mid-cycle, with a cycle stamp and the
  // running count of in_ready-low cycles.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (!reset && !bus8.in_ready) rlow8 <= rlow8 + 1;
    if (!reset && bus8.out_valid && bus8.out_ready)
      q8.push_back(makeRec(bus8.out_window, int'(bus8.out_x), bus8.out_last, cyc, rlow8));
    if (!reset && bus16.out_valid && bus16.out_ready)
      q16.push_back(makeRec(bus16.out_window, int'(bus16.out_x), bus16.out_last, cyc, 0));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference window: byte k = row pixel x-3+k clamped into the row.
  function automatic logic [63:0] modelWindow(input int x);
    logic [63:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      idx = x - 3 + k;
      if (idx < 0) idx = 0;
      if (idx > refW - 1) idx = refW - 1;
      w[8*k +: 8] = refRow[idx];
    end
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one pixel and returns just after the edge that accepts it.
  task automatic applyStimulus(input int dut, input logic [7:0] pix);
    int guard;
    logic rdy;
    guard = 0;
    if (dut == 8) begin
      bus8.in_valid = 1'b1;
      bus8.in_pixel = pix;
    end else begin
      bus16.in_valid = 1'b1;
      bus16.in_pixel = pix;
    end
    forever begin
      @(negedge clock);
      rdy = (dut == 8) ? bus8.in_ready : bus16.in_ready;
      if (rdy || guard >= 100) break;
      guard++;
      if (dut == 8) stall8++;
    end
    if (guard >= 100) checkOutput("in_ready_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic waitWindows(input int dut, input int count);
    int guard;
    int sz;
    guard = 0;
    sz = (dut == 8) ? q8.size() : q16.size();
    while (sz < count && guard < 200) begin
      tick();
      guard++;
      sz = (dut == 8) ? q8.size() : q16.size();
    end
    if (sz < count) checkOutput("wait_windows", sz, count);
  endtask

  task automatic checkRow(input string tag, input int base);
    for (int i = 0; i < 8; i++) begin
      if (base + i < q8.size()) begin
        checkOutput($sformatf("%s_x%0d", tag, i), q8[base+i].x, i);
        checkOutput($sformatf("%s_win%0d", tag, i), q8[base+i].window, modelWindow(i));
        checkOutput($sformatf("%s_last%0d", tag, i), q8[base+i].last, (i == 7));
      end else begin
        checkOutput($sformatf("%s_missing%0d", tag, i), q8.size(), base + i + 1);
      end
    end
  endtask

  task automatic setRow(input logic [7:0] first, input logic [7:0] step);
    for (int i = 0; i < 16; i++) refRow[i] = first + 8'(i) * step;
    refW = 8;
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.in_pixel   = '0;
    bus8.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_pixel  = '0;
    bus16.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_out_valid", bus8.out_valid, 1'b0);
    checkOutput("rst_out_window", bus8.out_window, 64'd0);
    checkOutput("rst_out_x", bus8.out_x, 3'd0);
    checkOutput("rst_in_ready", bus8.in_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("idle_in_ready", bus8.in_ready, 1'b1);
    tick();

    // Basic row 10..80
    q8.delete();
    setRow(8'd10, 8'd10);
    for (int i = 0; i < 8; i++) applyStimulus(8, refRow[i]);
    bus8.in_valid = 1'b0;
    waitWindows(8, 8);
    repeat (6) tick();
    checkOutput("basic_count", q8.size(), 8);
    if (q8.size() >= 8) begin
      checkOutput("basic_x0_hex", q8[0].window, 64'h32281E140A0A0A0A);
      checkOutput("basic_x7_hex", q8[7].window, 64'h5050505050463C32);
      checkOutput("basic_x7_last", q8[7].last, 1'b1);
    end
    checkRow("basic", 0);

    // Two back-to-back rows, continuous valid
    q8.delete();
    stall8 = 0;
    for (int i = 0; i < 8; i++) applyStimulus(8, 8'(i + 1));
    for (int i = 0; i < 8; i++) applyStimulus(8, 8'(101 + i));
    bus8.in_valid = 1'b0;
    waitWindows(8, 16);
    repeat (6) tick();
    checkOutput("tput_count", q8.size(), 16);
    checkOutput("tput_in_stalls", stall8, 4);
    if (q8.size() >= 16) begin
      checkOutput("tput_row1_span", q8[7].cyc - q8[0].cyc, 7);
      checkOutput("tput_row_gap", q8[8].cyc - q8[7].cyc, 5);
      checkOutput("tput_row2_span", q8[15].cyc - q8[8].cyc, 7);
      checkOutput("tput_ready_low", q8[15].rlow - q8[0].rlow, 8);
    end
    setRow(8'd1, 8'd1);
    checkRow("tput_r1", 0);
    setRow(8'd101, 8'd1);
    checkRow("tput_r2", 8);
    bad = 0;
    for (int i = 8; i < 16 && i < q8.size(); i++)
      for (int k = 0; k < 8; k++)
        if (q8[i].window[8*k +: 8] < 8'd101) bad++;
    checkOutput("tput_row2_clean", bad, 0);

    // Backpressure for 5 cycles mid-STREAM
    q8.delete();
    setRow(8'h31, 8'd1);
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(8, refRow[i]);
        bus8.in_valid = 1'b0;
      end
      begin
        int g;
        g = 0;
        forever begin
          @(negedge clock);
          #1;
          if (q8.size() >= 2 || g >= 100) break;
          g++;
        end
        tick();
        bus8.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clock);
          checkOutput($sformatf("bp_x_c%0d", c), bus8.out_x, 3'd2);
          checkOutput($sformatf("bp_win_c%0d", c), bus8.out_window, modelWindow(2));
          checkOutput($sformatf("bp_in_ready_c%0d", c), bus8.in_ready, 1'b0);
        end
        tick();
        bus8.out_ready = 1'b1;
      end
    join
    waitWindows(8, 8);
    repeat (6) tick();
    checkOutput("bp_count", q8.size(), 8);
    checkRow("bp", 0);

    // Stall while flushing
    q8.delete();
    setRow(8'h51, 8'd2);
    for (int i = 0; i < 8; i++) applyStimulus(8, refRow[i]);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checkOutput($sformatf("fs_x_c%0d", c), bus8.out_x, 3'd3);
      checkOutput($sformatf("fs_win_c%0d", c), bus8.out_window, modelWindow(3));
      checkOutput($sformatf("fs_in_ready_c%0d", c), bus8.in_ready, 1'b0);
    end
    tick();
    bus8.out_ready = 1'b1;
    waitWindows(8, 8);
    repeat (6) tick();
    checkOutput("fs_count", q8.size(), 8);
    checkRow("fs", 0);

    // Reset after 5 of 8 pixels
    setRow(8'h61, 8'd1);
    for (int i = 0; i < 5; i++) applyStimulus(8, refRow[i]);
    bus8.in_valid = 1'b0;
    checkOutput("pre_rst_valid", bus8.out_valid, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", bus8.out_valid, 1'b0);
    checkOutput("mid_rst_window", bus8.out_window, 64'd0);
    checkOutput("mid_rst_x", bus8.out_x, 3'd0);
    checkOutput("mid_rst_in_ready", bus8.in_ready, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    q8.delete();
    setRow(8'h71, 8'd3);
    for (int i = 0; i < 8; i++) applyStimulus(8, refRow[i]);
    bus8.in_valid = 1'b0;
    waitWindows(8, 8);
    repeat (6) tick();
    checkOutput("rst_row_count", q8.size(), 8);
    checkRow("rst_row", 0);

    // Constant image on the 16-wide instance
    q16.delete();
    for (int i = 0; i < 16; i++) applyStimulus(16, 8'hFF);
    bus16.in_valid = 1'b0;
    waitWindows(16, 16);
    repeat (6) tick();
    checkOutput("const_count", q16.size(), 16);
    for (int i = 0; i < 16 && i < q16.size(); i++) begin
      checkOutput($sformatf("const_x%0d", i), q16[i].x, i);
      checkOutput($sformatf("const_win%0d", i), q16[i].window, 64'hFFFFFFFFFFFFFFFF);
      checkOutput($sformatf("const_last%0d", i), q16[i].last, (i == 15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
